alu_exec_unit: RTL

Parametrised, registered integer execution unit for the out-of-order core; the successor to the single-cycle combinational ALU. It accepts one tagged operation per cycle from the reservation station over a valid/ready handshake. Single-cycle ops produce a registered result one cycle later. An iterative multiplier takes WIDTH cycles. Results and tags are held on a valid/ready output port until the common data bus grants them.

---
 rtl/alu_exec_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Registered integer execution unit: single-cycle ALU ops plus an iterative
// shift-add multiplier, with a valid/ready-held result register toward the CDB.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Resetb,
  input  logic             Flush,
  input  logic             Issue_Valid,
  output logic             Issue_Ready,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [SH_W-1:0]  Shfamt,
  input  logic [3:0]       ALU_Opcode,
  input  logic [TAG_W-1:0] Tag_In,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [TAG_W-1:0] Tag_Out,
  output logic             ALU_Branch,
  output logic             ALU_Branch_Taken,
  output logic             Carry_Out,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD = 4'h2, OP_ADDU = 4'h3,
                         OP_BEQ  = 4'h4, OP_BNQ  = 4'h5, OP_SUB = 4'h6, OP_SLT  = 4'h7,
                         OP_SLL  = 4'h8, OP_SRL  = 4'h9, OP_SLTU = 4'hA, OP_MUL = 4'hB,
                         OP_NOR  = 4'hC, OP_SRA  = 4'hD, OP_XOR = 4'hE;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

  state_t state_q, state_nxt;

  // Signed overflow of a + b_eff = s, where b_eff is the operand actually fed to the adder.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic signed [WIDTH-1:0] op1_s, op2_s;
  logic        [WIDTH:0]   add_sum, sub_sum;
  logic        [WIDTH-1:0] res_c;
  logic                    br_c, tk_c, co_c, ov_c;

  assign op1_s   = Operand1;
  assign op2_s   = Operand2;
  assign add_sum = {1'b0, Operand1} + {1'b0, Operand2};
  assign sub_sum = {1'b0, Operand1} + {1'b0, ~Operand2} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_c = '0;
    br_c  = 1'b0;
    tk_c  = 1'b0;
    co_c  = 1'b0;
    ov_c  = 1'b0;
    case (ALU_Opcode)
      OP_AND:  res_c = Operand1 & Operand2;
      OP_OR:   res_c = Operand1 | Operand2;
      OP_NOR:  res_c = ~(Operand1 | Operand2);
      OP_XOR:  res_c = Operand1 ^ Operand2;
      OP_ADD: begin
        res_c = add_sum[WIDTH-1:0];
        co_c  = add_sum[WIDTH];
        ov_c  = add_ovf(Operand1[WIDTH-1], Operand2[WIDTH-1], add_sum[WIDTH-1]);
      end
      OP_ADDU: begin
        res_c = add_sum[WIDTH-1:0];
        co_c  = add_sum[WIDTH];
      end
      OP_SUB: begin
        res_c = sub_sum[WIDTH-1:0];
        co_c  = sub_sum[WIDTH];
        ov_c  = add_ovf(Operand1[WIDTH-1], ~Operand2[WIDTH-1], sub_sum[WIDTH-1]);
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, (op1_s < op2_s)};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (Operand1 < Operand2)};
      OP_SLL:  res_c = Operand1 << Shfamt;
      OP_SRL:  res_c = Operand1 >> Shfamt;
      OP_SRA:  res_c = op1_s >>> Shfamt;
      OP_BEQ: begin
        br_c = 1'b1;
        tk_c = (Operand1 == Operand2);
      end
      OP_BNQ: begin
        br_c = 1'b1;
        tk_c = (Operand1 != Operand2);
      end
      default: ;
    endcase
  end

  logic slot_free, accept, accept_mul, load_alu, load_mul;
  logic [2*WIDTH-1:0] mul_a_p0, acc_p0, acc_nxt, prod_c;
  logic [WIDTH-1:0]   mul_b_p0;
  logic [TAG_W-1:0]   mul_tag_p0;
  logic [CNT_W-1:0]   cnt_p0;

  assign slot_free   = !Out_Valid || Out_Ready;
  assign Issue_Ready = (state_q == IDLE) && slot_free && !Flush;
  assign accept      = Issue_Valid && Issue_Ready;
  assign accept_mul  = accept && (ALU_Opcode == OP_MUL);
  assign load_alu    = accept && (ALU_Opcode != OP_MUL);
  // The last partial product is folded in combinationally so the product lands on the count-1 edge.
  assign acc_nxt     = acc_p0 + (mul_b_p0[0] ? mul_a_p0 : '0);
  assign prod_c      = (state_q == MUL_DONE) ? acc_p0 : acc_nxt;
  assign load_mul    = slot_free &&
                       (((state_q == MUL_RUN) && (cnt_p0 == CNT_W'(1))) || (state_q == MUL_DONE));

  always_comb begin
    state_nxt = state_q;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (accept_mul) state_nxt = MUL_RUN;
        MUL_RUN:  if (cnt_p0 == CNT_W'(1)) state_nxt = slot_free ? IDLE : MUL_DONE;
        MUL_DONE: if (slot_free) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // Multiplier stage: operands shift, accumulator gathers partial products.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      cnt_p0     <= '0;
      mul_a_p0   <= '0;
      mul_b_p0   <= '0;
      acc_p0     <= '0;
      mul_tag_p0 <= '0;
    end else if (Flush) begin
      cnt_p0 <= '0;
    end else if (accept_mul) begin
      cnt_p0     <= CNT_W'(WIDTH);
      mul_a_p0   <= {{WIDTH{1'b0}}, Operand1};
      mul_b_p0   <= Operand2;
      acc_p0     <= '0;
      mul_tag_p0 <= Tag_In;
    end else if (state_q == MUL_RUN) begin
      cnt_p0   <= cnt_p0 - CNT_W'(1);
      mul_a_p0 <= mul_a_p0 << 1;
      mul_b_p0 <= mul_b_p0 >> 1;
      acc_p0   <= acc_nxt;
    end
  end

  // Output stage: held until the CDB grants it.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      Out_Valid        <= 1'b0;
      Result           <= '0;
      Tag_Out          <= '0;
      ALU_Branch       <= 1'b0;
      ALU_Branch_Taken <= 1'b0;
      Carry_Out        <= 1'b0;
      Overflow         <= 1'b0;
    end else if (Flush) begin
      Out_Valid <= 1'b0;
    end else if (load_alu) begin
      Out_Valid        <= 1'b1;
      Result           <= res_c;
      Tag_Out          <= Tag_In;
      ALU_Branch       <= br_c;
      ALU_Branch_Taken <= tk_c;
      Carry_Out        <= co_c;
      Overflow         <= ov_c;
    end else if (load_mul) begin
      Out_Valid        <= 1'b1;
      Result           <= prod_c[WIDTH-1:0];
      Tag_Out          <= mul_tag_p0;
      ALU_Branch       <= 1'b0;
      ALU_Branch_Taken <= 1'b0;
      Carry_Out        <= 1'b0;
      Overflow         <= |prod_c[2*WIDTH-1:WIDTH];
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule
